// File: rtl/mmio_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : mmio_port_bank
// Brief    : Memory-mapped GPIO bank with per-bit direction, input
//            synchronisers and optional change-event capture with irq.
//            Optional feature macro: MMIO_PORT_EVENT_EN (EVENT/MASK/irq).
// Revision : 1.0
// ============================================================================
module mmio_port_bank #(
    parameter int          NUM_PORTS    = 8,
    parameter int          PORT_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'hFFFFFF00,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [31:0]                      address,
    input  logic [31:0]                      writeData,
    input  logic [3:0]                       byteEnable,
    input  logic                             writeEnable,
    input  logic                             readEnable,
    output logic                             hit,
    output logic [31:0]                      readData,
    output logic                             readValid,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0]  portInputs,
    output logic [NUM_PORTS*PORT_WIDTH-1:0]  portOutputs,
    output logic [NUM_PORTS*PORT_WIDTH-1:0]  portDirections,
    output logic                             irq
);
    localparam int          c_busWidth   = NUM_PORTS * PORT_WIDTH;
    localparam logic [31:0] c_portSpan   = 32'(16 * NUM_PORTS);
    localparam logic [31:0] c_windowSpan = 32'(16 * NUM_PORTS + 4);

    function automatic logic [31:0] byteSwap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] r_out;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] r_dir;
    logic [c_busWidth-1:0]                r_sync [SYNC_STAGES];
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] w_in;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] w_eventView;
    logic [NUM_PORTS-1:0]                 w_maskView;
    logic [31:0] w_offset, w_wrValue, w_laneMask, w_rdValue;
    logic [31:0] r_readData;
    logic        r_readValid;
    logic [4:0]  w_port;
    logic [1:0]  w_reg;
    logic        w_inPorts, w_isMask, w_aligned, w_wrStrobe;

    assign w_offset   = address - BASE_ADDRESS;
    assign hit        = (address >= BASE_ADDRESS) && (w_offset < c_windowSpan);
    assign w_inPorts  = hit && (w_offset < c_portSpan);
    assign w_isMask   = hit && !w_inPorts;
    assign w_aligned  = (address[1:0] == 2'b00);
    assign w_port     = w_offset[8:4];
    assign w_reg      = w_offset[3:2];
    assign w_wrStrobe = writeEnable && hit && w_aligned;
    assign w_wrValue  = byteSwap(writeData);
    // Enable bit j selects register byte j once the bus swap is undone.
    assign w_laneMask = {{8{byteEnable[3]}}, {8{byteEnable[2]}},
                         {8{byteEnable[1]}}, {8{byteEnable[0]}}};
    assign w_in       = r_sync[SYNC_STAGES-1];

    assign portOutputs    = r_out;
    assign portDirections = r_dir;
    assign readData       = r_readData;
    assign readValid      = r_readValid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= portInputs;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
            r_dir <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_wrStrobe && w_inPorts && (w_port == i[4:0])) begin
                    if (w_reg == 2'd1)
                        r_out[i] <= (r_out[i] & ~w_laneMask[PORT_WIDTH-1:0])
                                  | (w_wrValue[PORT_WIDTH-1:0] & w_laneMask[PORT_WIDTH-1:0]);
                    if (w_reg == 2'd2)
                        r_dir[i] <= (r_dir[i] & ~w_laneMask[PORT_WIDTH-1:0])
                                  | (w_wrValue[PORT_WIDTH-1:0] & w_laneMask[PORT_WIDTH-1:0]);
                end
            end
        end
    end

`ifdef MMIO_PORT_EVENT_EN
    localparam logic [2:0] c_settleDone = 3'(SYNC_STAGES + 1);

    logic [2:0]                           r_settle;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] r_prev, r_event, w_evSet, w_evClr;
    logic [NUM_PORTS-1:0]                 r_mask, w_evAny;
    logic                                 r_irq;

    always_comb begin
        w_evSet = '0;
        w_evClr = '0;
        w_evAny = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // Edges seen while the synchronisers are still filling are not real.
            if (r_settle == c_settleDone)
                w_evSet[i] = (w_in[i] ^ r_prev[i]) & ~r_dir[i];
            if (w_wrStrobe && w_inPorts && (w_port == i[4:0]) && (w_reg == 2'd3))
                w_evClr[i] = w_wrValue[PORT_WIDTH-1:0] & w_laneMask[PORT_WIDTH-1:0];
            w_evAny[i] = |r_event[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_settle <= '0;
            r_prev   <= '0;
            r_event  <= '0;
            r_mask   <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (r_settle != c_settleDone) r_settle <= r_settle + 3'd1;
            r_prev  <= w_in;
            r_event <= (r_event & ~w_evClr) | w_evSet;
            if (w_wrStrobe && w_isMask)
                r_mask <= (r_mask & ~w_laneMask[NUM_PORTS-1:0])
                        | (w_wrValue[NUM_PORTS-1:0] & w_laneMask[NUM_PORTS-1:0]);
            r_irq <= |(r_mask & w_evAny);
        end
    end

    assign w_eventView = r_event;
    assign w_maskView  = r_mask;
    assign irq         = r_irq;
`else
    assign w_eventView = '0;
    assign w_maskView  = '0;
    assign irq         = 1'b0;
`endif

    always_comb begin
        w_rdValue = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_inPorts && (w_port == i[4:0])) begin
                case (w_reg)
                    2'd0:    w_rdValue = 32'(w_in[i]);
                    2'd1:    w_rdValue = 32'(r_out[i]);
                    2'd2:    w_rdValue = 32'(r_dir[i]);
                    default: w_rdValue = 32'(w_eventView[i]);
                endcase
            end
        end
        if (w_isMask) w_rdValue = 32'(w_maskView);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_readData  <= '0;
            r_readValid <= 1'b0;
        end else begin
            r_readValid <= readEnable && hit;
            if (readEnable && hit)
                r_readData <= w_aligned ? byteSwap(w_rdValue) : 32'd0;
        end
    end

endmodule
`default_nettype wire
